// File: rtl/mux2a1_ochobits_condl1tx.sv
// Two-lane to one-lane byte serializer running at twice the lane-word rate.
// Each lane pair is captured in PH_CAP, then emitted lane 0 first and lane 1 second.
module mux2a1_ochobits_condl1tx #(
  parameter logic [7:0] IDLE_WORD = 8'hBC,
  parameter int         COUNT_W   = 8
) (
  input  logic               clk_2f,
  input  logic               reset,
  input  logic               valid_in0,
  input  logic [7:0]         data_in0,
  input  logic               valid_in1,
  input  logic [7:0]         data_in1,
  output logic               valid_out,
  output logic [7:0]         data_out,
  output logic               phase,
  output logic [COUNT_W-1:0] word_count,
  output logic               lane_mismatch
);

  typedef enum logic {
    PH_CAP  = 1'b0,
    PH_SEND = 1'b1
  } phase_t;

  phase_t             state_r, state_nxt_s;
  logic               hold0_valid_r, hold0_valid_nxt_s;
  logic [7:0]         hold0_data_r, hold0_data_nxt_s;
  logic               hold1_valid_r, hold1_valid_nxt_s;
  logic [7:0]         hold1_data_r, hold1_data_nxt_s;
  logic               load_valid_s;
  logic [7:0]         load_data_s;
  logic               out_valid_r, out_valid_nxt_s;
  logic [7:0]         out_data_r, out_data_nxt_s;
  logic [COUNT_W-1:0] count_r, count_nxt_s;
  logic               mismatch_r, mismatch_nxt_s;

  // Saturating increment: the counter parks at all-ones instead of wrapping.
  function automatic logic [COUNT_W-1:0] sat_inc(input logic [COUNT_W-1:0] val);
    if (val == {COUNT_W{1'b1}}) begin
      sat_inc = val;
    end else begin
      sat_inc = val + COUNT_W'(1);
    end
  endfunction

  // Next-state, hold capture and slot selection.
  always_comb begin
    state_nxt_s       = state_r;
    hold0_valid_nxt_s = hold0_valid_r;
    hold0_data_nxt_s  = hold0_data_r;
    hold1_valid_nxt_s = hold1_valid_r;
    hold1_data_nxt_s  = hold1_data_r;
    mismatch_nxt_s    = mismatch_r;
    load_valid_s      = 1'b0;
    load_data_s       = 8'h00;
    case (state_r)
      PH_CAP: begin
        // Lane 1 of the previous pair leaves while the new pair is taken in.
        load_valid_s      = hold1_valid_r;
        load_data_s       = hold1_data_r;
        hold0_valid_nxt_s = valid_in0;
        hold0_data_nxt_s  = data_in0;
        hold1_valid_nxt_s = valid_in1;
        hold1_data_nxt_s  = data_in1;
        mismatch_nxt_s    = mismatch_r | (valid_in0 ^ valid_in1);
        state_nxt_s       = PH_SEND;
      end
      PH_SEND: begin
        load_valid_s = hold0_valid_r;
        load_data_s  = hold0_data_r;
        state_nxt_s  = PH_CAP;
      end
      default: begin
        state_nxt_s = PH_CAP;
      end
    endcase
    if (load_valid_s) begin
      out_valid_nxt_s = 1'b1;
      out_data_nxt_s  = load_data_s;
      count_nxt_s     = sat_inc(count_r);
    end else begin
      out_valid_nxt_s = 1'b0;
      out_data_nxt_s  = IDLE_WORD;
      count_nxt_s     = count_r;
    end
  end

  // State, hold and output registers; reset wins over everything.
  always_ff @(posedge clk_2f) begin
    if (reset) begin
      state_r       <= PH_CAP;
      hold0_valid_r <= 1'b0;
      hold0_data_r  <= 8'h00;
      hold1_valid_r <= 1'b0;
      hold1_data_r  <= 8'h00;
      out_valid_r   <= 1'b0;
      out_data_r    <= IDLE_WORD;
      count_r       <= {COUNT_W{1'b0}};
      mismatch_r    <= 1'b0;
    end else begin
      state_r       <= state_nxt_s;
      hold0_valid_r <= hold0_valid_nxt_s;
      hold0_data_r  <= hold0_data_nxt_s;
      hold1_valid_r <= hold1_valid_nxt_s;
      hold1_data_r  <= hold1_data_nxt_s;
      out_valid_r   <= out_valid_nxt_s;
      out_data_r    <= out_data_nxt_s;
      count_r       <= count_nxt_s;
      mismatch_r    <= mismatch_nxt_s;
    end
  end

  assign valid_out     = out_valid_r;
  assign data_out      = out_data_r;
  assign phase         = state_r;
  assign word_count    = count_r;
  assign lane_mismatch = mismatch_r;

endmodule

// File: tb/tb_mux2a1_ochobits_condl1tx.sv
// Bench for the two-lane serializer: directed steps then random traffic against a
// slot-queue reference model; a second instance with a 2-bit counter checks saturation.
module tb_mux2a1_ochobits_condl1tx;

  logic       clk_2f = 1'b0;
  logic       reset;
  logic       valid_in0, valid_in1;
  logic [7:0] data_in0, data_in1;
  logic       valid_out, valid_out_b;
  logic [7:0] data_out, data_out_b;
  logic       phase, phase_b;
  logic [7:0] word_count;
  logic [1:0] word_count_b;
  logic       lane_mismatch, lane_mismatch_b;

  int checks = 0;
  int errors = 0;

  // Reference model: expected slots queued in emission order.
  logic [8:0] q[$];
  logic       m_phase = 1'b0;
  logic       e_valid = 1'b0;
  logic [7:0] e_data = 8'hBC;
  int         sent = 0;
  logic       m_mm = 1'b0;

  always #5 clk_2f = ~clk_2f;

  mux2a1_ochobits_condl1tx dut (
    .clk_2f(clk_2f), .reset(reset),
    .valid_in0(valid_in0), .data_in0(data_in0),
    .valid_in1(valid_in1), .data_in1(data_in1),
    .valid_out(valid_out), .data_out(data_out), .phase(phase),
    .word_count(word_count), .lane_mismatch(lane_mismatch)
  );

  mux2a1_ochobits_condl1tx #(.COUNT_W(2)) dut_b (
    .clk_2f(clk_2f), .reset(reset),
    .valid_in0(valid_in0), .data_in0(data_in0),
    .valid_in1(valid_in1), .data_in1(data_in1),
    .valid_out(valid_out_b), .data_out(data_out_b), .phase(phase_b),
    .word_count(word_count_b), .lane_mismatch(lane_mismatch_b)
  );

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_edge(input logic r, input logic v0, input logic [7:0] d0,
                         input logic v1, input logic [7:0] d1);
    logic [8:0] s;
    reset = r; valid_in0 = v0; data_in0 = d0; valid_in1 = v1; data_in1 = d1;
    @(posedge clk_2f);
    if (r) begin
      q.delete();
      m_phase = 1'b0; e_valid = 1'b0; e_data = 8'hBC; sent = 0; m_mm = 1'b0;
    end else begin
      s = (q.size() > 0) ? q.pop_front() : 9'h000;
      e_valid = s[8];
      e_data  = s[8] ? s[7:0] : 8'hBC;
      if (s[8]) sent++;
      if (!m_phase) begin
        q.push_back({v0, d0});
        q.push_back({v1, d1});
        if (v0 != v1) m_mm = 1'b1;
      end
      m_phase = ~m_phase;
    end
    #1;
    chk("valid_out", 32'(valid_out), 32'(e_valid));
    chk("data_out", 32'(data_out), 32'(e_data));
    chk("phase", 32'(phase), 32'(m_phase));
    chk("word_count", 32'(word_count), (sent > 255) ? 32'd255 : 32'(sent));
    chk("word_count_w2", 32'(word_count_b), (sent > 3) ? 32'd3 : 32'(sent));
    chk("lane_mismatch", 32'(lane_mismatch), 32'(m_mm));
  endtask

  // A send-phase edge with random lane garbage, which must be ignored.
  task automatic junk_edge();
    do_edge(1'b0, 1'($urandom), 8'($urandom), 1'($urandom), 8'($urandom));
  endtask

  task automatic pair(input logic v0, input logic [7:0] d0, input logic v1, input logic [7:0] d1);
    if (m_phase) junk_edge();
    do_edge(1'b0, v0, d0, v1, d1);
    junk_edge();
  endtask

  initial begin
    // Reset and idle lanes
    do_edge(1'b1, 1'b0, 8'h00, 1'b0, 8'h00);
    do_edge(1'b1, 1'b0, 8'h00, 1'b0, 8'h00);
    for (int i = 0; i < 6; i++) do_edge(1'b0, 1'b0, 8'h00, 1'b0, 8'h00);
    chk("idle_count", 32'(word_count), 32'd0);

    // Single pair, then flush
    pair(1'b1, 8'hA5, 1'b1, 8'h3C);
    pair(1'b0, 8'h00, 1'b0, 8'h00);
    chk("pair_count", 32'(word_count), 32'd2);

    // Back-to-back pairs
    pair(1'b1, 8'h01, 1'b1, 8'h02);
    pair(1'b1, 8'h03, 1'b1, 8'h04);
    pair(1'b1, 8'h05, 1'b1, 8'h06);
    pair(1'b0, 8'h00, 1'b0, 8'h00);
    chk("b2b_count", 32'(word_count), 32'd8);

    // Mismatched lanes, sticky flag through matched traffic
    pair(1'b1, 8'h11, 1'b0, 8'h22);
    pair(1'b1, 8'h33, 1'b1, 8'h44);
    pair(1'b0, 8'h00, 1'b0, 8'h00);
    chk("mismatch_sticky", 32'(lane_mismatch), 32'd1);

    // Reset mid-pair discards the held lane-1 word
    do_edge(1'b1, 1'b0, 8'h00, 1'b0, 8'h00);
    do_edge(1'b0, 1'b1, 8'hAA, 1'b1, 8'hBB);
    do_edge(1'b1, 1'b0, 8'h00, 1'b0, 8'h00);
    for (int i = 0; i < 4; i++) begin
      do_edge(1'b0, 1'b0, 8'h00, 1'b0, 8'h00);
      chk("no_bb", 32'(valid_out && data_out == 8'hBB), 32'd0);
    end

    // Saturation of the narrow counter
    for (int i = 0; i < 3; i++) pair(1'b1, 8'(8'h50 + i), 1'b1, 8'(8'h60 + i));
    pair(1'b0, 8'h00, 1'b0, 8'h00);
    chk("sat_w2", 32'(word_count_b), 32'd3);

    // Random traffic with occasional resets
    for (int i = 0; i < 400; i++) begin
      do_edge(($urandom_range(0, 39) == 0), ($urandom_range(0, 3) != 0), 8'($urandom),
              ($urandom_range(0, 3) != 0), 8'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
